// File: rtl/serial_hdx_pkg.sv
// Shared types and helpers for the half-duplex 8N1 serial bridge.
package serial_hdx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    GUARD,
    RX_START,
    RX_DATA,
    RX_STOP
  } hdx_state_e;

  // 8N1 frame layout.
  localparam int unsigned START_BITS = 1;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;

  // Clock cycles per bit.
  function automatic int unsigned div_calc(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/serial_hdx_baud_tick.sv
// Bit-period down-counter. Reloads with DIV-1 (or DIV/2-1 for the RX
// half-bit preload) and emits tick_o in the last cycle of each period.
// pre_tick_o flags the cycle just before tick_o.
module serial_hdx_baud_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic load_full_i,
  input  logic load_half_i,
  output logic tick_o,
  output logic pre_tick_o
);

  localparam int unsigned    CW   = $clog2(DIV);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: explicit loads first, parked at zero when disabled,
  // otherwise count down and auto-reload on the tick.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
    cnt_d = cnt_q;
    if (load_half_i) begin
      cnt_d = HALF;
    end else if (load_full_i) begin
      cnt_d = FULL;
    end else if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = FULL;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o     = en_i && (cnt_q == '0);
  assign pre_tick_o = en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/serial_hdx_bridge.sv
// Half-duplex 8N1 UART engine for ESC passthrough. Drives the pad mux TX
// data/OE, receives from the mux's synchronized idle-high RX line, and owns
// line turnaround with a post-transmit guard that masks our own echo.
// Optional build macro SERIAL_HDX_RX_TIMEOUT_EN adds rx_idle_o, a one-shot
// packet-delimiter pulse after TIMEOUT_BITS idle bit times following RX.
module serial_hdx_bridge
  import serial_hdx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 54_000_000,
  parameter int unsigned BAUD         = 19_200,
  parameter int unsigned GUARD_BITS   = 2
`ifdef SERIAL_HDX_RX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_BITS = 20
`endif
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  output logic       busy_o,
  output logic       serial_tx_o,
  output logic       serial_oe_o,
  input  logic       serial_rx_i
`ifdef SERIAL_HDX_RX_TIMEOUT_EN
  ,
  output logic       rx_idle_o
`endif
);

  localparam int unsigned   DIV        = div_calc(CLK_FREQ_HZ, BAUD);
  localparam int unsigned   GW         = (GUARD_BITS > 1) ? $clog2(GUARD_BITS) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_BITS - 1);
  localparam logic [2:0]    LAST_BIT   = 3'(DATA_BITS - 1);

  hdx_state_e    state_q, state_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          tx_ready_q, tx_ready_d;
  logic          line_tx_q, line_tx_d;
  logic          line_oe_q, line_oe_d;

  logic tick, pre_tick, load_full, load_half, baud_en, tx_accept;

  assign baud_en = (state_q != IDLE);

  serial_hdx_baud_tick #(.DIV(DIV)) u_baud (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_n_i),
    .en_i       (baud_en),
    .load_full_i(load_full),
    .load_half_i(load_half),
    .tick_o     (tick),
    .pre_tick_o (pre_tick)
  );

  // A start edge in IDLE masks the registered ready in the same cycle, so
  // RX wins a collision without the host seeing a dropped handshake.
  assign tx_ready_o = tx_ready_q & ~((state_q == IDLE) & ~serial_rx_i);
  assign tx_accept  = tx_valid_i & tx_ready_o;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    guard_d    = guard_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    load_full  = 1'b0;
    load_half  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!serial_rx_i) begin
          state_d   = RX_START;
          load_half = 1'b1;
        end else if (tx_accept) begin
          state_d    = TX_START;
          tx_shift_d = tx_data_i;
          load_full  = 1'b1;
        end
      end
      TX_START: begin
        if (tick) begin
          state_d   = TX_DATA;
          bit_idx_d = '0;
        end
      end
      TX_DATA: begin
        if (tick) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_accept) begin
            state_d    = TX_START;
            tx_shift_d = tx_data_i;
          end else begin
            state_d = GUARD;
            guard_d = '0;
          end
        end
      end
      GUARD: begin
        if (tick) begin
          guard_d = guard_q + GW'(1);
          if (guard_q == GUARD_LAST) state_d = IDLE;
        end
      end
      RX_START: begin
        if (tick) begin
          if (serial_rx_i) begin
            state_d = IDLE;
          end else begin
            state_d   = RX_DATA;
            bit_idx_d = '0;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_shift_d = {serial_rx_i, rx_shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = serial_rx_i;
          rx_ferr_d  = ~serial_rx_i;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready opens in IDLE and for the final cycle of a stop bit.
    tx_ready_d = (state_d == IDLE) || ((state_q == TX_STOP) && pre_tick);
    line_oe_d  = state_d inside {TX_START, TX_DATA, TX_STOP};
    if (state_d == TX_START)     line_tx_d = 1'b0;
    else if (state_d == TX_DATA) line_tx_d = tx_shift_d[0];
    else                         line_tx_d = 1'b1;
  end

  // State and output registers; reset drops OE asynchronously.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      guard_q    <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_ready_q <= 1'b0;
      line_tx_q  <= 1'b1;
      line_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      guard_q    <= guard_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_ready_q <= tx_ready_d;
      line_tx_q  <= line_tx_d;
      line_oe_q  <= line_oe_d;
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_ferr_o   = rx_ferr_q;
  assign serial_tx_o = line_tx_q;
  assign serial_oe_o = line_oe_q;
  assign busy_o      = (state_q != IDLE);

`ifdef SERIAL_HDX_RX_TIMEOUT_EN
  localparam int unsigned   IDLE_CYCLES = TIMEOUT_BITS * DIV;
  localparam int unsigned   IW          = $clog2(IDLE_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(IDLE_CYCLES - 1);

  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          idle_armed_q, idle_armed_d;
  logic          rx_idle_q, rx_idle_d;

  // Idle timer: armed by any RX strobe, disarmed by TX acceptance or by
  // firing once; restarts whenever the line leaves IDLE.
  always_comb begin
    idle_cnt_d   = idle_cnt_q;
    idle_armed_d = idle_armed_q;
    rx_idle_d    = 1'b0;
    if (rx_valid_d || rx_ferr_d) begin
      idle_armed_d = 1'b1;
      idle_cnt_d   = '0;
    end else if (tx_accept) begin
      idle_armed_d = 1'b0;
      idle_cnt_d   = '0;
    end else if ((state_q != IDLE) || !serial_rx_i) begin
      idle_cnt_d = '0;
    end else if (idle_armed_q) begin
      if (idle_cnt_q == IDLE_LAST) begin
        rx_idle_d    = 1'b1;
        idle_armed_d = 1'b0;
        idle_cnt_d   = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + IW'(1);
      end
    end
  end

  // Idle timer registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      idle_cnt_q   <= '0;
      idle_armed_q <= 1'b0;
      rx_idle_q    <= 1'b0;
    end else begin
      idle_cnt_q   <= idle_cnt_d;
      idle_armed_q <= idle_armed_d;
      rx_idle_q    <= rx_idle_d;
    end
  end

  assign rx_idle_o = rx_idle_q;
`endif

endmodule

// File: tb/tb_serial_hdx_bridge.sv
// Directed bench for serial_hdx_bridge at DIV=10, GUARD_BITS=2.
module tb_serial_hdx_bridge;

  localparam int DIV   = 10;
  localparam int GUARD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr, busy, serial_tx, serial_oe;
  logic       rx_drv = 1'b1;
  logic       loopback = 1'b0;
  logic       serial_rx;

  assign serial_rx = loopback ? serial_tx : rx_drv;

  always #5 clk = ~clk;

`ifdef SERIAL_HDX_RX_TIMEOUT_EN
  logic rx_idle;
`endif

  serial_hdx_bridge #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD       (100_000),
    .GUARD_BITS (GUARD)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ferr_o  (rx_ferr),
    .busy_o     (busy),
    .serial_tx_o(serial_tx),
    .serial_oe_o(serial_oe),
    .serial_rx_i(serial_rx)
`ifdef SERIAL_HDX_RX_TIMEOUT_EN
    ,
    .rx_idle_o  (rx_idle)
`endif
  );

  // Cycle counter and output monitors (sampled on the falling edge).
  int cyc = 0;
  int valid_cnt = 0, ferr_cnt = 0, valid_cyc = 0, oe_rise_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic oe_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
      last_data <= rx_data;
    end
    if (rx_ferr) ferr_cnt <= ferr_cnt + 1;
    if (serial_oe && !oe_prev) oe_rise_cyc <= cyc;
    oe_prev <= serial_oe;
  end

`ifdef SERIAL_HDX_RX_TIMEOUT_EN
  int idle_cnt = 0, idle_cyc = 0;
  always @(negedge clk) begin
    if (rx_idle) begin
      idle_cnt <= idle_cnt + 1;
      idle_cyc <= cyc;
    end
  end
`endif

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one byte and check every line cycle, the stop-bit ready window,
  // OE release and the guard length.
  task automatic send_tx(input logic [7:0] data, input logic [9:0] exp_frame, input string tag);
    int bad;
    int n;
    check($sformatf("%s ready in idle", tag), 32'(tx_ready), 1);
    tx_data  = data;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < DIV; c++) begin
        if (serial_tx !== exp_frame[b] || serial_oe !== 1'b1) bad++;
        if (b == 9 && c == DIV - 2) check($sformatf("%s ready before last stop cycle", tag), 32'(tx_ready), 0);
        if (b == 9 && c == DIV - 1) check($sformatf("%s ready in last stop cycle", tag), 32'(tx_ready), 1);
        tick();
      end
      check($sformatf("%s bit%0d wrong cycles", tag, b), bad, 0);
    end
    check($sformatf("%s oe released", tag), 32'(serial_oe), 0);
    check($sformatf("%s line idle high", tag), 32'(serial_tx), 1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check($sformatf("%s guard cycles", tag), n, GUARD * DIV);
  endtask

  task automatic drive_frame(input logic [7:0] data, input logic stop);
    logic [9:0] f;
    f = {stop, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_drv = f[b];
      repeat (DIV) tick();
    end
    rx_drv = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_frame;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_rx_data;
  } rx_vec_t;

  tx_vec_t tx_tab[3];
  rx_vec_t rx_tab[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v0, f0, t0, n, bad, overlap;
    logic [7:0] d0;
    logic [9:0] f;
    logic [9:0] f00;
    logic [9:0] fff;

    tx_tab[0] = '{8'hA5, 10'b1_1010_0101_0};
    tx_tab[1] = '{8'h01, 10'b1_0000_0001_0};
    tx_tab[2] = '{8'h80, 10'b1_1000_0000_0};

    rx_tab[0] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    rx_tab[1] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    rx_tab[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    rx_tab[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    rx_tab[4] = '{8'h81, 1'b0, 0, 1, 8'h81};
    rx_tab[5] = '{8'h5A, 1'b1, 1, 0, 8'h5A};

    // Reset values.
    #12;
    check("reset serial_tx", 32'(serial_tx), 1);
    check("reset serial_oe", 32'(serial_oe), 0);
    check("reset tx_ready", 32'(tx_ready), 0);
    check("reset rx_valid", 32'(rx_valid), 0);
    check("reset rx_ferr", 32'(rx_ferr), 0);
    check("reset rx_data", 32'(rx_data), 0);
    check("reset busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    check("post-reset ready", 32'(tx_ready), 1);

    // Single-byte transmissions.
    for (int i = 0; i < 3; i++) begin
      send_tx(tx_tab[i].data, tx_tab[i].exp_frame, $sformatf("tx[%0d]", i));
    end

    // Back-to-back 0x00 then 0xFF with valid held.
    f00 = 10'b1_0000_0000_0;
    fff = 10'b1_1111_1111_0;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'hFF;
    bad = 0;
    for (int c = 0; c < 20 * DIV; c++) begin
      if (c < 10 * DIV) begin
        if (serial_tx !== f00[c / DIV]) bad++;
      end else begin
        if (serial_tx !== fff[(c - 10 * DIV) / DIV]) bad++;
      end
      if (serial_oe !== 1'b1) bad++;
      if (c == 10 * DIV) tx_valid = 1'b0;
      tick();
    end
    check("b2b contiguous frames", bad, 0);
    check("b2b oe released", 32'(serial_oe), 0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("b2b guard cycles", n, GUARD * DIV);

    // Receive table.
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      t0 = cyc;
      drive_frame(rx_tab[i].data, rx_tab[i].stop);
      repeat (20) tick();
      check($sformatf("rx[%0d] valid pulses", i), valid_cnt - v0, rx_tab[i].exp_valid);
      check($sformatf("rx[%0d] ferr pulses", i), ferr_cnt - f0, rx_tab[i].exp_ferr);
      check($sformatf("rx[%0d] rx_data", i), 32'(rx_data), 32'(rx_tab[i].exp_rx_data));
      if (rx_tab[i].exp_valid == 1) check($sformatf("rx[%0d] strobe latency", i), valid_cyc - t0, 96);
      check($sformatf("rx[%0d] busy settled", i), 32'(busy), 0);
    end

    // Short low glitch is rejected at the half-bit sample.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    d0 = rx_data;
    rx_drv = 1'b0;
    repeat (3) tick();
    rx_drv = 1'b1;
    check("glitch busy during start check", 32'(busy), 1);
    repeat (15) tick();
    check("glitch busy cleared", 32'(busy), 0);
    check("glitch no strobe", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    check("glitch data held", 32'(rx_data), 32'(d0));

    // Echo suppression, then a frame 25 cycles after OE release.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    loopback = 1'b1;
    send_tx(8'h3C, 10'b1_0011_1100_0, "echo");
    repeat (5) tick();
    loopback = 1'b0;
    check("echo no strobe", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    drive_frame(8'hC3, 1'b1);
    repeat (20) tick();
    check("post-guard frame received", valid_cnt - v0, 1);
    check("post-guard frame data", 32'(last_data), 32'hC3);
`ifdef SERIAL_HDX_RX_TIMEOUT_EN
    n = idle_cnt;
    repeat (200) tick();
    check("idle pulse count", idle_cnt - n, 1);
    check("idle pulse delay", idle_cyc - valid_cyc, 200);
    repeat (250) tick();
    check("idle no re-pulse", idle_cnt - n, 1);
`endif

    // Start edge and tx_valid in the same IDLE cycle: RX wins.
    v0 = valid_cnt;
    t0 = cyc;
    f = {1'b1, 8'h3C, 1'b0};
    rx_drv   = 1'b0;
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    #1;
    check("collision ready masked", 32'(tx_ready), 0);
    overlap = 0;
    for (int b = 0; b < 10; b++) begin
      rx_drv = f[b];
      for (int c = 0; c < DIV; c++) begin
        if (serial_oe === 1'b1 && valid_cnt == v0) overlap++;
        if (serial_oe === 1'b1) tx_valid = 1'b0;
        tick();
      end
    end
    rx_drv = 1'b1;
    check("collision rx strobe", valid_cnt - v0, 1);
    check("collision rx data", 32'(last_data), 32'h3C);
    check("collision oe overlap cycles", overlap, 0);
    check("collision tx follows rx", oe_rise_cyc - valid_cyc, 1);
    check("collision tx accepted", 32'(tx_valid), 0);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("collision tx completes", 32'(n < 300), 1);
`ifdef SERIAL_HDX_RX_TIMEOUT_EN
    n = idle_cnt;
    repeat (300) tick();
    check("idle cleared by tx", idle_cnt - n, 0);
`endif

    // Reset mid-frame drops OE immediately.
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (35) tick();
    check("midframe oe high", 32'(serial_oe), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset oe", 32'(serial_oe), 0);
    check("async reset tx", 32'(serial_tx), 1);
    check("async reset busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("recovered ready", 32'(tx_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_hdx_bridge.md
Name: serial_hdx_bridge

Overview:
- Half-duplex 8N1 UART engine for ESC passthrough (BLHeli 4-way style). Sits at the far end of the motor-pad serial/DSHOT mux.
- Drives the mux's serial TX data and TX output-enable inputs, and consumes the mux's synchronized, idle-high RX output.
- Host side is a byte stream: valid/ready for TX, a one-cycle valid strobe for RX.
- Owns line turnaround: OE is asserted only while transmitting, followed by a post-transmit guard that suppresses echo.

Parameters:
CLK_FREQ_HZ, 54_000_000, system clock frequency.
BAUD, 19_200, line bit rate. DIV = CLK_FREQ_HZ/BAUD (integer division, must be ≥ 4).
GUARD_BITS, 2, bit times after the last stop bit during which RX is ignored.
TIMEOUT_BITS, 20, idle bit times before rx_idle_o pulses (optional feature only).

Ports:
wb_clk_i  in  1  system clock.
wb_rst_n_i  in  1  reset, asynchronous assert, active-low.
tx_data_i  in  8  byte to send.
tx_valid_i  in  1  tx_data_i valid.
tx_ready_o  out  1  bridge accepts a byte this cycle.
rx_data_o  out  8  received byte.
rx_valid_o  out  1  one-cycle strobe, rx_data_o valid.
rx_ferr_o  out  1  one-cycle strobe, stop bit sampled low.
busy_o  out  1  TX, guard or RX in progress.
serial_tx_o  out  1  line data to mux.
serial_oe_o  out  1  line drive enable to mux (1 = drive).
serial_rx_i  in  1  synchronized line level from mux (idle 1).

Behaviour:
- Reset values: serial_tx_o=1, serial_oe_o=0, tx_ready_o=0, rx_valid_o=0, rx_ferr_o=0, rx_data_o=0, busy_o=0. FSM returns to IDLE; baud counter=0.
- Reset asserted mid-frame aborts the frame immediately; OE drops asynchronously.
- Baud timing: a single down-counter reloads with DIV-1 per bit. RX samples at count DIV/2 after the start edge is detected, then every DIV cycles.
- FSM states: IDLE, TX_START, TX_DATA, TX_STOP, GUARD, RX_START, RX_DATA, RX_STOP.
- IDLE:
  - tx_ready_o=1 (registered).
  - tx_valid_i&tx_ready_o captures the byte → TX_START.
  - Else, serial_rx_i==0 → RX_START.
  - If both occur in the same cycle, RX wins: tx_ready_o is already deasserted that cycle, so no byte is accepted.
- TX_START: serial_oe_o=1 and serial_tx_o=0 for DIV cycles, starting the cycle after acceptance.
- TX_DATA: 8 bits, LSB first, DIV cycles each; a 3-bit index 0→7.
- TX_STOP: serial_tx_o=1 for DIV cycles. In the last cycle of the stop bit, tx_ready_o=1 for one cycle.
  - If accepted: go back-to-back to TX_START with OE held high, no gap.
  - Else: serial_oe_o=0 and serial_tx_o=1 the next cycle → GUARD.
- GUARD: GUARD_BITS*DIV cycles; serial_rx_i is ignored and tx_ready_o=0. Then → IDLE.
- RX_START:
  - At the half-bit point, if serial_rx_i==1 the edge was a glitch → IDLE with no strobe.
  - Else → RX_DATA.
- RX_DATA: shift 8 samples LSB first.
- RX_STOP: sample at the stop-bit midpoint.
  - Sample 1: rx_data_o updates and rx_valid_o pulses one cycle.
  - Sample 0: rx_data_o still updates, rx_ferr_o pulses instead of rx_valid_o.
  - Then → IDLE immediately, ready for the next start edge one half-bit later.
- No RX backpressure: the consumer must take rx_data_o on the strobe; it is held until the next strobe.
- busy_o = (state != IDLE).
- serial_oe_o is never 1 outside TX_START/TX_DATA/TX_STOP.

Optional Feature:
SERIAL_HDX_RX_TIMEOUT_EN.
- Defined:
  - Adds output rx_idle_o (1 bit, reset 0).
  - An idle counter runs in IDLE after the last RX strobe (valid or ferr).
  - After TIMEOUT_BITS*DIV cycles with no start edge, rx_idle_o pulses once. It does not re-pulse until another byte is received.
  - Any TX acceptance clears the counter without pulsing. Used by the host as a packet delimiter.
- Undefined: the port is absent; no counter logic.

Decomposition:
- Package serial_hdx_pkg holds:
  - state enum typedef;
  - localparams for frame bits (START=1, DATA=8, STOP=1);
  - function div_calc(clk, baud).
- A sub-module, serial_hdx_baud_tick, is natural: reloadable down-counter with a half-bit preload, emitting a tick pulse.
- The FSM stays in serial_hdx_bridge.

Test Plan (CLK_FREQ_HZ=1_000_000, BAUD=100_000 → DIV=10, GUARD_BITS=2):
- Send 0xA5 → line is 0,1,0,1,0,0,1,0,1,1, each held 10 cycles. serial_oe_o is high for exactly 100 cycles, then low; busy_o falls 20 cycles later.
- Back-to-back 0x00 then 0xFF with tx_valid held → OE high for 200 contiguous cycles; no idle gap between stop bit and next start bit.
- Drive frame 0x3C on serial_rx_i → rx_valid_o pulses once with rx_data_o=0x3C, about 95 cycles after the start edge; rx_ferr_o stays 0.
- Frame with stop bit forced 0 → rx_ferr_o pulses, rx_valid_o stays 0. A 3-cycle low glitch is rejected with no strobe.
- Echo: loop serial_tx_o back to serial_rx_i during TX and guard → no rx_valid_o. A frame starting 25 cycles after OE release (guard has expired) is received.
- Start edge and tx_valid_i in the same IDLE cycle → RX completes first, the TX byte is accepted afterwards, and OE never overlaps RX. With SERIAL_HDX_RX_TIMEOUT_EN, rx_idle_o pulses 200 cycles after that RX strobe only if no TX is accepted in the meantime.
